// File: rtl/sdram_frame_sequencer.sv
// Burst request sequencer between the pixel FIFOs and sdram_top (133 MHz domain).
// It loads one frame of rows into SDRAM, then replays the rows into the read FIFO on every VGA frame.
module sdram_frame_sequencer #(
   parameter int ROWS_PER_FRAME = 128,
   parameter int WR_THRESH      = 512,
   parameter int RD_THRESH      = 512,
   parameter int FIFO_UW        = 11
) (
   input  logic               clk_133M,
   input  logic               rst_133,
   input  logic [FIFO_UW-1:0] wr_fifo_used,
   input  logic [FIFO_UW-1:0] rd_fifo_used,
   input  logic               vsync_i,
   input  logic               reload_i,
   output logic               wr_sdram_req,
   input  logic               wr_sdram_ack,
   output logic [23:0]        wr_sdram_add,
   output logic               rd_sdram_req,
   input  logic               rd_sdram_ack,
   output logic [23:0]        rd_sdram_add,
   output logic               frame_written,
   output logic               rd_underrun,
   output logic [7:0]         wr_row
);

   typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

   localparam logic [7:0]         ROWS  = 8'(ROWS_PER_FRAME);
   localparam logic [FIFO_UW-1:0] WR_TH = FIFO_UW'(WR_THRESH);
   localparam logic [FIFO_UW-1:0] RD_TH = FIFO_UW'(RD_THRESH);

   // Bank and column are always zero; the row sits in bits [21:9].
   function automatic logic [23:0] row_addr(input logic [7:0] row);
      return {2'b00, 5'b00000, row, 9'b000000000};
   endfunction

   state_t      state_q, state_d;
   logic        vs_meta_q, vs_meta_d, vs_s_q, vs_s_d, vs_prev_q, vs_prev_d;
   logic        wr_req_q, wr_req_d, rd_req_q, rd_req_d;
   logic [23:0] wr_add_q, wr_add_d, rd_add_q, rd_add_d;
   logic [7:0]  wr_row_q, wr_row_d, rd_row_q, rd_row_d;
   logic        frame_written_q, frame_written_d;
   logic        rd_underrun_q, rd_underrun_d;
   logic        restart_q, restart_d;
   logic        reload_pend_q, reload_pend_d;
   logic        vs_low, vs_fall;

   assign vs_low  = ~vs_s_q;
   assign vs_fall = vs_prev_q & ~vs_s_q;

   // Next-state, request and counter logic.
   always_comb begin
      state_d         = state_q;
      vs_meta_d       = vsync_i;
      vs_s_d          = vs_meta_q;
      vs_prev_d       = vs_s_q;
      wr_req_d        = wr_req_q;
      rd_req_d        = rd_req_q;
      wr_add_d        = wr_add_q;
      rd_add_d        = rd_add_q;
      wr_row_d        = wr_row_q;
      rd_row_d        = rd_row_q;
      frame_written_d = frame_written_q;
      rd_underrun_d   = rd_underrun_q;
      restart_d       = restart_q;
      reload_pend_d   = reload_pend_q;

      case (state_q)
         IDLE: begin
            if (reload_i || reload_pend_q) begin
               wr_row_d        = 8'd0;
               frame_written_d = 1'b0;
               restart_d       = 1'b1;
               reload_pend_d   = 1'b0;
            end else if (vs_low || restart_q) begin
               rd_row_d  = 8'd0;
               restart_d = 1'b0;
            end else if (frame_written_q && (rd_row_q < ROWS) && (rd_fifo_used <= RD_TH)) begin
               state_d  = RD;
               rd_req_d = 1'b1;
               rd_add_d = row_addr(rd_row_q);
            end else if (!frame_written_q && (wr_fifo_used >= WR_TH)) begin
               state_d  = WR;
               wr_req_d = 1'b1;
               wr_add_d = row_addr(wr_row_q);
            end else begin
               state_d = IDLE;
            end
         end
         WR: begin
            if (reload_i) begin
               reload_pend_d = 1'b1;
            end else begin
               reload_pend_d = reload_pend_q;
            end
            if (wr_sdram_ack) begin
               state_d  = IDLE;
               wr_req_d = 1'b0;
               if (wr_row_q < ROWS) begin
                  wr_row_d = wr_row_q + 8'd1;
               end else begin
                  wr_row_d = wr_row_q;
               end
               if ((wr_row_q + 8'd1) >= ROWS) begin
                  frame_written_d = 1'b1;
               end else begin
                  frame_written_d = frame_written_q;
               end
            end else begin
               state_d = WR;
            end
         end
         RD: begin
            if (reload_i) begin
               reload_pend_d = 1'b1;
            end else begin
               reload_pend_d = reload_pend_q;
            end
            if (rd_sdram_ack) begin
               state_d  = IDLE;
               rd_req_d = 1'b0;
               rd_row_d = rd_row_q + 8'd1;
            end else begin
               state_d = RD;
            end
         end
         default: begin
            state_d  = IDLE;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
         end
      endcase

      // A vsync edge outranks the IDLE clear so no frame start is ever lost.
      if (vs_fall) begin
         restart_d = 1'b1;
         if (frame_written_q && (rd_row_q < ROWS)) begin
            rd_underrun_d = 1'b1;
         end else begin
            rd_underrun_d = rd_underrun_q;
         end
      end else begin
         restart_d = restart_d;
      end
   end

   // State and output registers.
   always_ff @(posedge clk_133M or negedge rst_133) begin
      if (!rst_133) begin
         state_q         <= IDLE;
         vs_meta_q       <= 1'b0;
         vs_s_q          <= 1'b0;
         vs_prev_q       <= 1'b0;
         wr_req_q        <= 1'b0;
         rd_req_q        <= 1'b0;
         wr_add_q        <= 24'd0;
         rd_add_q        <= 24'd0;
         wr_row_q        <= 8'd0;
         rd_row_q        <= 8'd0;
         frame_written_q <= 1'b0;
         rd_underrun_q   <= 1'b0;
         restart_q       <= 1'b0;
         reload_pend_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         vs_meta_q       <= vs_meta_d;
         vs_s_q          <= vs_s_d;
         vs_prev_q       <= vs_prev_d;
         wr_req_q        <= wr_req_d;
         rd_req_q        <= rd_req_d;
         wr_add_q        <= wr_add_d;
         rd_add_q        <= rd_add_d;
         wr_row_q        <= wr_row_d;
         rd_row_q        <= rd_row_d;
         frame_written_q <= frame_written_d;
         rd_underrun_q   <= rd_underrun_d;
         restart_q       <= restart_d;
         reload_pend_q   <= reload_pend_d;
      end
   end

   assign wr_sdram_req  = wr_req_q;
   assign rd_sdram_req  = rd_req_q;
   assign wr_sdram_add  = wr_add_q;
   assign rd_sdram_add  = rd_add_q;
   assign wr_row        = wr_row_q;
   assign frame_written = frame_written_q;
   assign rd_underrun   = rd_underrun_q;

endmodule

// File: tb/tb_sdram_frame_sequencer.sv
// Directed bench for sdram_frame_sequencer: a vector table for the IDLE request decision,
// plus hand-written burst sequences for frame load, readback, vsync restart and reload.
module tb_sdram_frame_sequencer;

   logic        clk_133M = 1'b0;
   logic        rst_133;
   logic [10:0] wr_fifo_used;
   logic [10:0] rd_fifo_used;
   logic        vsync_i;
   logic        reload_i;
   logic        wr_sdram_req;
   logic        wr_sdram_ack;
   logic [23:0] wr_sdram_add;
   logic        rd_sdram_req;
   logic        rd_sdram_ack;
   logic [23:0] rd_sdram_add;
   logic        frame_written;
   logic        rd_underrun;
   logic [7:0]  wr_row;

   int errors = 0;
   int checks = 0;

   sdram_frame_sequencer dut (
      .clk_133M      (clk_133M),
      .rst_133       (rst_133),
      .wr_fifo_used  (wr_fifo_used),
      .rd_fifo_used  (rd_fifo_used),
      .vsync_i       (vsync_i),
      .reload_i      (reload_i),
      .wr_sdram_req  (wr_sdram_req),
      .wr_sdram_ack  (wr_sdram_ack),
      .wr_sdram_add  (wr_sdram_add),
      .rd_sdram_req  (rd_sdram_req),
      .rd_sdram_ack  (rd_sdram_ack),
      .rd_sdram_add  (rd_sdram_add),
      .frame_written (frame_written),
      .rd_underrun   (rd_underrun),
      .wr_row        (wr_row)
   );

   always #5 clk_133M = ~clk_133M;

   typedef struct {
      logic [10:0] wr_used;
      logic [10:0] rd_used;
      int          cycles;
      logic        exp_wr_req;
      logic        exp_rd_req;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apply_vec(input int i);
      wr_fifo_used = vecs[i].wr_used;
      rd_fifo_used = vecs[i].rd_used;
      repeat (vecs[i].cycles) @(negedge clk_133M);
      check($sformatf("vec%0d wr_req", i), 32'(wr_sdram_req), 32'(vecs[i].exp_wr_req));
      check($sformatf("vec%0d rd_req", i), 32'(rd_sdram_req), 32'(vecs[i].exp_rd_req));
   endtask

   task automatic wait_req(input logic is_rd, input string nm);
      int n = 0;
      while (((is_rd ? rd_sdram_req : wr_sdram_req) !== 1'b1) && (n < 50)) begin
         @(negedge clk_133M);
         n++;
      end
      check({nm, " req timeout"}, 32'(is_rd ? rd_sdram_req : wr_sdram_req), 32'd1);
   endtask

   // Waits for a request, checks its address, holds it for delay cycles, acks it.
   task automatic do_burst(input logic is_rd, input int row, input int delay, input string nm);
      logic [31:0] exp_add;
      exp_add = 32'(row) << 9;
      wait_req(is_rd, nm);
      check({nm, " addr"}, 32'(is_rd ? rd_sdram_add : wr_sdram_add), exp_add);
      repeat (delay) @(negedge clk_133M);
      check({nm, " req held"}, 32'(is_rd ? rd_sdram_req : wr_sdram_req), 32'd1);
      check({nm, " addr held"}, 32'(is_rd ? rd_sdram_add : wr_sdram_add), exp_add);
      if (is_rd) rd_sdram_ack = 1'b1;
      else       wr_sdram_ack = 1'b1;
      @(negedge clk_133M);
      rd_sdram_ack = 1'b0;
      wr_sdram_ack = 1'b0;
      check({nm, " req drop"}, 32'(is_rd ? rd_sdram_req : wr_sdram_req), 32'd0);
   endtask

   initial begin
      vecs[0] = '{wr_used: 11'd511, rd_used: 11'd600, cycles: 8, exp_wr_req: 1'b0, exp_rd_req: 1'b0};
      vecs[1] = '{wr_used: 11'd0,   rd_used: 11'd0,   cycles: 4, exp_wr_req: 1'b0, exp_rd_req: 1'b0};
      vecs[2] = '{wr_used: 11'd512, rd_used: 11'd600, cycles: 1, exp_wr_req: 1'b1, exp_rd_req: 1'b0};
      vecs[3] = '{wr_used: 11'd600, rd_used: 11'd513, cycles: 6, exp_wr_req: 1'b0, exp_rd_req: 1'b0};
      vecs[4] = '{wr_used: 11'd600, rd_used: 11'd512, cycles: 1, exp_wr_req: 1'b0, exp_rd_req: 1'b1};

      rst_133      = 1'b0;
      wr_fifo_used = 11'd511;
      rd_fifo_used = 11'd600;
      vsync_i      = 1'b1;
      reload_i     = 1'b0;
      wr_sdram_ack = 1'b0;
      rd_sdram_ack = 1'b0;
      repeat (3) @(negedge clk_133M);
      check("rst wr_req", 32'(wr_sdram_req), 32'd0);
      check("rst rd_req", 32'(rd_sdram_req), 32'd0);
      check("rst wr_add", 32'(wr_sdram_add), 32'd0);
      check("rst rd_add", 32'(rd_sdram_add), 32'd0);
      check("rst frame_written", 32'(frame_written), 32'd0);
      check("rst rd_underrun", 32'(rd_underrun), 32'd0);
      check("rst wr_row", 32'(wr_row), 32'd0);
      rst_133 = 1'b1;

      // Write thresholds: 511 never requests, 512 requests one cycle later.
      for (int i = 0; i < 3; i++) apply_vec(i);

      // Full frame load, ack after 10 cycles.
      for (int r = 0; r < 128; r++) begin
         do_burst(1'b0, r, 10, $sformatf("wr row%0d", r));
         check($sformatf("wr_row after ack %0d", r), 32'(wr_row), 32'(r + 1));
         check($sformatf("frame_written after ack %0d", r), 32'(frame_written), 32'(r == 127));
      end
      repeat (20) @(negedge clk_133M);
      check("no 129th write", 32'(wr_sdram_req), 32'd0);
      check("wr_row saturated", 32'(wr_row), 32'd128);

      // Read threshold: 513 stalls, 512 requests.
      for (int i = 3; i < 5; i++) apply_vec(i);
      rd_fifo_used = 11'd100;

      // Full frame readback, with a stall after row 2.
      for (int r = 0; r < 128; r++) begin
         do_burst(1'b1, r, 2, $sformatf("rd row%0d", r));
         if (r == 2) begin
            rd_fifo_used = 11'd513;
            repeat (6) @(negedge clk_133M);
            check("rd stalled at 513", 32'(rd_sdram_req), 32'd0);
            rd_fifo_used = 11'd512;
         end
      end
      repeat (10) @(negedge clk_133M);
      check("no 129th read", 32'(rd_sdram_req), 32'd0);
      check("no underrun after full frame", 32'(rd_underrun), 32'd0);

      // Vsync pulse after a complete frame: no underrun, restart at row 0.
      vsync_i = 1'b0;
      repeat (6) @(negedge clk_133M);
      vsync_i = 1'b1;
      repeat (6) @(negedge clk_133M);
      check("no underrun on clean vsync", 32'(rd_underrun), 32'd0);
      for (int r = 0; r < 5; r++) do_burst(1'b1, r, 2, $sformatf("rd frame2 row%0d", r));

      // Vsync arrives during the row-5 burst: request held until ack, underrun flagged.
      wait_req(1'b1, "rd row5");
      check("rd row5 addr", 32'(rd_sdram_add), 32'h000A00);
      vsync_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_133M);
         check($sformatf("rd req held in vsync %0d", k), 32'(rd_sdram_req), 32'd1);
      end
      check("rd_underrun set", 32'(rd_underrun), 32'd1);
      rd_sdram_ack = 1'b1;
      @(negedge clk_133M);
      rd_sdram_ack = 1'b0;
      check("rd row5 req drop", 32'(rd_sdram_req), 32'd0);
      repeat (4) @(negedge clk_133M);
      check("no read during vsync", 32'(rd_sdram_req), 32'd0);
      vsync_i = 1'b1;

      // Restarted read at row 0; reload pulse during it is applied after its ack.
      wait_req(1'b1, "rd restart");
      check("rd restart addr", 32'(rd_sdram_add), 32'd0);
      reload_i = 1'b1;
      @(negedge clk_133M);
      reload_i = 1'b0;
      @(negedge clk_133M);
      check("rd req held across reload", 32'(rd_sdram_req), 32'd1);
      rd_sdram_ack = 1'b1;
      @(negedge clk_133M);
      rd_sdram_ack = 1'b0;
      check("fw before reload applies", 32'(frame_written), 32'd1);
      @(negedge clk_133M);
      check("fw cleared by reload", 32'(frame_written), 32'd0);
      check("wr_row cleared by reload", 32'(wr_row), 32'd0);
      check("underrun sticky", 32'(rd_underrun), 32'd1);

      // Reload during the row-40 write burst.
      for (int r = 0; r < 40; r++) do_burst(1'b0, r, 1, $sformatf("rewr row%0d", r));
      check("no read while reloading", 32'(rd_sdram_req), 32'd0);
      wait_req(1'b0, "wr row40");
      check("wr row40 addr", 32'(wr_sdram_add), 32'h005000);
      reload_i = 1'b1;
      @(negedge clk_133M);
      reload_i = 1'b0;
      @(negedge clk_133M);
      wr_sdram_ack = 1'b1;
      @(negedge clk_133M);
      wr_sdram_ack = 1'b0;
      check("wr_row counts row40 ack", 32'(wr_row), 32'd41);
      @(negedge clk_133M);
      check("wr_row reloaded", 32'(wr_row), 32'd0);
      check("fw after reload", 32'(frame_written), 32'd0);
      wait_req(1'b0, "wr after reload");
      check("wr after reload addr", 32'(wr_sdram_add), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
